// File: rtl/encoder8to3_serializer.sv
// Registered 8-to-3 encoder: serializes each set bit of a request vector
// as a 3-bit index beat. Build macro ENC_LSB_FIRST_EN selects LSB-first order.
module encoder8to3_serializer #(
  parameter int ZERO_PASS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out,
  output logic       out_zero,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t     state, state_n;
  logic [7:0] pend, pend_n;
  logic       zflag, zflag_n;
  logic [2:0] idx;
  logic       onehot;

  // Priority encode the pending bits; the later loop hit wins.
  always_comb begin
    idx = '0;
`ifdef ENC_LSB_FIRST_EN
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) idx = 3'(i);
    end
`else
    for (int i = 0; i < 8; i++) begin
      if (pend[i]) idx = 3'(i);
    end
`endif
  end

  assign onehot = (pend != 8'd0) &&
                  ((pend & (pend - 8'd1)) == 8'd0);

  // State, pending bits and zero-beat flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      zflag <= zflag_n;
    end
  end

  // Next-state and handshake/beat outputs.
  always_comb begin
    state_n   = state;
    pend_n    = pend;
    zflag_n   = zflag;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out       = '0;
    out_zero  = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in != 8'd0) begin
            pend_n  = in;
            zflag_n = 1'b0;
            state_n = EMIT;
          end else if (ZERO_PASS != 0) begin
            pend_n  = '0;
            zflag_n = 1'b1;
            state_n = EMIT;
          end
        end
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out       = zflag ? 3'd0 : idx;
        out_zero  = zflag;
        out_last  = zflag | onehot;
        if (out_ready) begin
          pend_n = pend & ~(8'd1 << idx);
          if (out_last) begin
            pend_n  = '0;
            zflag_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder8to3_serializer.sv
// Scoreboard bench for encoder8to3_serializer: random vectors and
// backpressure against a bit-list reference model.
module tb_encoder8to3_serializer;

  typedef struct packed {
    logic [2:0] idx;
    logic       z;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out;
  logic       out_zero;
  logic       out_last;
  logic       busy;

  logic       z_in_valid = 1'b0;
  logic       z_in_ready;
  logic [7:0] z_in = '0;
  logic       z_out_valid;
  logic       z_out_ready = 1'b1;
  logic [2:0] z_out;
  logic       z_out_zero;
  logic       z_out_last;
  logic       z_busy;

  int    checks = 0;
  int    errors = 0;
  int    hs_cnt = 0;
  bit    rnd_en = 1'b0;
  beat_t sb[$];
  bit    held = 1'b0;
  beat_t hv;

  encoder8to3_serializer #(.ZERO_PASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_zero(out_zero), .out_last(out_last),
    .busy(busy)
  );

  encoder8to3_serializer #(.ZERO_PASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in(z_in),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out(z_out), .out_zero(z_out_zero), .out_last(z_out_last),
    .busy(z_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of set bits in priority order.
  task automatic model_push(input logic [7:0] v);
    int order[$];
    beat_t b;
    if (v == 8'd0) begin
      b.idx = 3'd0; b.z = 1'b1; b.l = 1'b1;
      sb.push_back(b);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (v[i]) order.push_back(i);
    end
`ifndef ENC_LSB_FIRST_EN
    order.reverse();
`endif
    foreach (order[k]) begin
      b.idx = 3'(order[k]);
      b.z   = 1'b0;
      b.l   = (k == order.size() - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    in_valid = 1'b1;
    in = v;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", int'(in_ready), 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    model_push(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in = 8'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 400);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_ready"}, int'(in_ready), 1);
    chk({name, "_out"}, int'(out), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_zero"}, int'(out_zero), 0);
    chk({name, "_last"}, int'(out_last), 0);
  endtask

  // Monitor: compares every handshaked beat and checks hold under stall.
  always @(negedge clk) begin
    beat_t cur;
    cur.idx = out; cur.z = out_zero; cur.l = out_last;
    if (!rst_n || !out_valid) begin
      held = 1'b0;
    end else begin
      if (held) chk("hold_stable", int'(cur), int'(hv));
      if (out_ready) begin
        held = 1'b0;
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("extra_beat", int'(cur), -1);
        end else begin
          chk("beat", int'(cur), int'(sb.pop_front()));
        end
      end else begin
        held = 1'b1;
        hv = cur;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int n;
    int h0;
    int hi_i, lo_i;
    logic [4:0] pat;
    int e_out[5];
    int e_last[5];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-bit vectors.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'd1 << i);
      wait_idle(n);
      chk("single_ir_lag", n, 2);
    end

    // Multi-bit vector, one beat per cycle.
    send(8'b1010_0101);
    wait_idle(n);
    chk("multi_cycles", n, 5);

    // Backpressure on 8'hC0.
`ifdef ENC_LSB_FIRST_EN
    hi_i = 6; lo_i = 7;
`else
    hi_i = 7; lo_i = 6;
`endif
    e_out  = '{hi_i, hi_i, hi_i, lo_i, lo_i};
    e_last = '{0, 0, 0, 1, 1};
    pat = 5'b10100;
    out_ready = 1'b0;
    h0 = hs_cnt;
    send(8'hC0);
    for (int k = 0; k < 5; k++) begin
      out_ready = pat[k];
      @(negedge clk);
      chk("bp_out", int'(out), e_out[k]);
      chk("bp_last", int'(out_last), e_last[k]);
      @(posedge clk);
      #1;
    end
    chk("bp_handshakes", hs_cnt - h0, 2);
    @(negedge clk);
    chk("bp_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Zero vector, ZERO_PASS=1.
    send(8'h00);
    wait_idle(n);
    chk("zero_cycles", n, 2);

    // Zero vector, ZERO_PASS=0: dropped silently.
    z_in_valid = 1'b1;
    z_in = 8'h00;
    repeat (4) begin
      @(negedge clk);
      chk("zp0_ready", int'(z_in_ready), 1);
      chk("zp0_valid", int'(z_out_valid), 0);
    end
    z_in_valid = 1'b0;

    // Reset mid-vector.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'hFF);
    @(negedge clk);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // Random vectors with random backpressure.
    rnd_en = 1'b1;
    for (int v = 0; v < 500; v++) begin
      if ($urandom_range(0, 9) == 0) send(8'h00);
      else send(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_en = 1'b0;
    out_ready = 1'b1;
    wait_idle(n);
    chk("drain_idle", int'(in_ready), 1);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder8to3_serializer.md
# encoder8to3_serializer

Registered 8-to-3 encoder that is the reverse direction of the team's 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one beat per bit, in priority order. Each beat is flagged with a last-beat marker. The block sits between request-collecting logic and any consumer that needs binary indices, such as a downstream 3-to-8 decoder or an arbiter.

## Interface
Parameters:
- ZERO_PASS, default 1: 1 = an all-zero vector produces one beat with `out_zero`=1; 0 = an all-zero vector is accepted and dropped silently.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request vector valid
- in_ready  output  1  block can accept a vector
- in  input  8  request vector; bit i = request for index i
- out_valid  output  1  encoded beat valid
- out_ready  input  1  consumer accepts the beat
- out  output  3  encoded index of the current set bit
- out_zero  output  1  beat represents an empty vector (ZERO_PASS=1 only)
- out_last  output  1  final beat for the current vector
- busy  output  1  a vector is being serialized (state != IDLE)

## Operation
- Two states: IDLE and EMIT. The `pend[7:0]` register holds the bits not yet emitted.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready` with `in`!=0: `pend`<=`in`, go to EMIT.
  - With `in`==0 and ZERO_PASS=1: go to EMIT with `pend`=0 and the zero flag set.
  - With `in`==0 and ZERO_PASS=0: stay IDLE; no beat is produced.
- EMIT:
  - `in_ready`=0 and `out_valid`=1.
  - `out` = index of the highest set bit of `pend` (bit 7 highest priority). With `ENC_LSB_FIRST_EN` defined, it is the lowest set bit instead.
  - `out_last`=1 when `pend` has exactly one bit set, or on the zero beat.
  - On `out_valid && out_ready`: clear the emitted bit in `pend`. If `out_last` was 1, return to IDLE.
- Beat count per vector equals popcount(`in`), or exactly 1 for a zero vector when ZERO_PASS=1.
- `out`, `out_zero` and `out_last` hold stable while `out_valid && !out_ready`.
- `out`=0 and `out_zero`=1 on the zero beat. `out_zero`=0 on all other beats.
- `in` is sampled only at handshake. Changes on `in` during EMIT are ignored.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `pend`=0, `out_valid`=0, `out`=0, `out_zero`=0, `out_last`=0, `busy`=0, `in_ready`=1.
- Latency: a vector accepted at edge N gives its first `out_valid` in the cycle after edge N (registered output).
- With `out_ready` held high, one beat per cycle. After the last beat handshakes at edge M, `in_ready`=1 in the cycle after M.
- Throughput: popcount+1 cycles per vector with no backpressure. No overlap between vectors.
- `out_ready` low stalls indefinitely; no beat is lost or duplicated.
- `out_ready` asserted while `out_valid`=0 has no effect.
- Reset asserted mid-vector aborts the vector: remaining beats are discarded and outputs go to reset values immediately.
- Reset deassertion is synchronized by the integrating design. The block's first active edge is the first rising `clk` after `rst_n` rises.

## Configuration
- Macro: `ENC_LSB_FIRST_EN`.
  - Undefined (default): MSB-first priority. Vector 8'b1000_0001 emits 7 then 0.
  - Defined: LSB-first priority. The same vector emits 0 then 7.
- The macro changes only scan order. Handshake, latency and `out_last` rules are identical in both builds.

## Test plan
- Reset check: assert `rst_n`=0 mid-operation, then release -> `out_valid`=0, `in_ready`=1, `out`=0, `busy`=0.
- Single-bit vectors: send `in`=8'h01,02,...,80 one at a time with `out_ready`=1 -> one beat each with `out`=0..7 and `out_last`=1, and `in_ready` back high 2 cycles after acceptance.
- Multi-bit vector, MSB-first: `in`=8'b1010_0101, `out_ready`=1 -> beats 7,5,2,0 on consecutive cycles, `out_last` only on 0. With `ENC_LSB_FIRST_EN`: 0,2,5,7.
- Backpressure: `in`=8'hC0 with `out_ready` toggled 0,0,1,0,1 -> `out`=7 held for 3 cycles, then 6 with `out_last`=1; exactly 2 handshakes.
- Zero vector: `in`=8'h00 with ZERO_PASS=1 -> one beat, `out_zero`=1, `out_last`=1, `out`=0. With ZERO_PASS=0 -> no `out_valid` and `in_ready` stays 1.
- Random: 500 random vectors with random `out_ready` -> the scoreboard reconstructs the OR of the emitted beats equal to `in` for every vector, in the correct order, with no extra beats.
